// File: rtl/alu_issue_ctrl.sv
// Command sequencer in front of the TotalALU: registers the ALU drive, waits out
// the MULTU latency, auto-issues MFHI/MFLO and buffers one result word at a time.
module alu_issue_ctrl #(
   parameter int MUL_WAIT = 35,
   parameter int DW       = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [5:0]    cmd_funct,
   input  logic [DW-1:0] cmd_a,
   input  logic [DW-1:0] cmd_b,
   output logic [5:0]    alu_signal,
   output logic [DW-1:0] alu_dataA,
   output logic [DW-1:0] alu_dataB,
   input  logic [DW-1:0] alu_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic          res_hi,
   output logic          res_err,
   output logic          busy
);

   // state   | meaning
   // IDLE    | waiting for a command, cmd_ready=1
   // EXEC    | single-cycle op driven, capture alu_out at the edge
   // MUL     | Signal=25 held while the multiplier runs (wait counter)
   // MFHI    | Signal=16 driven, capture Hi word
   // RESP_HI | Hi word waiting for release
   // MFLO    | Signal=18 driven, capture Lo word
   // RESP    | final result waiting for release
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EXEC    = 3'd1,
      MUL     = 3'd2,
      MFHI    = 3'd3,
      RESP_HI = 3'd4,
      MFLO    = 3'd5,
      RESP    = 3'd6
   } state_t;

   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;

   localparam int CW = (MUL_WAIT > 1) ? $clog2(MUL_WAIT + 1) : 1;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [5:0]      sig_n;
   logic [DW-1:0]   a_n, b_n, rd_n;
   logic            rv_n, rh_n, re_n;
   logic            single_op;

   assign single_op = (cmd_funct == F_AND) || (cmd_funct == F_OR)  ||
                      (cmd_funct == F_ADD) || (cmd_funct == F_SUB) ||
                      (cmd_funct == F_SLT) || (cmd_funct == F_SRL);

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         alu_signal <= '0;
         alu_dataA  <= '0;
         alu_dataB  <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_hi     <= 1'b0;
         res_err    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         alu_signal <= sig_n;
         alu_dataA  <= a_n;
         alu_dataB  <= b_n;
         res_valid  <= rv_n;
         res_data   <= rd_n;
         res_hi     <= rh_n;
         res_err    <= re_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sig_n   = alu_signal;
      a_n     = alu_dataA;
      b_n     = alu_dataB;
      rv_n    = res_valid;
      rd_n    = res_data;
      rh_n    = res_hi;
      re_n    = res_err;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (single_op) begin
                  a_n     = cmd_a;
                  b_n     = cmd_b;
                  sig_n   = cmd_funct;
                  state_n = EXEC;
               end else if (cmd_funct == F_MULTU) begin
                  a_n     = cmd_a;
                  b_n     = cmd_b;
                  sig_n   = F_MULTU;
                  cnt_n   = CW'(MUL_WAIT - 1);
                  state_n = MUL;
               end else begin
                  // illegal code: the ALU drive is left exactly as it was
                  rd_n    = '0;
                  re_n    = 1'b1;
                  rh_n    = 1'b0;
                  rv_n    = 1'b1;
                  state_n = RESP;
               end
            end
         end
         EXEC: begin
            rd_n    = alu_out;
            re_n    = 1'b0;
            rh_n    = 1'b0;
            rv_n    = 1'b1;
            state_n = RESP;
         end
         MUL: begin
            if (cnt == '0) begin
               sig_n   = F_MFHI;
               state_n = MFHI;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         MFHI: begin
            rd_n    = alu_out;
            re_n    = 1'b0;
            rh_n    = 1'b1;
            rv_n    = 1'b1;
            state_n = RESP_HI;
         end
         RESP_HI: begin
            if (res_ready) begin
               rv_n    = 1'b0;
               sig_n   = F_MFLO;
               state_n = MFLO;
            end
         end
         MFLO: begin
            rd_n    = alu_out;
            re_n    = 1'b0;
            rh_n    = 1'b0;
            rv_n    = 1'b1;
            state_n = RESP;
         end
         RESP: begin
            if (res_ready) begin
               rv_n    = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural TotalALU stand-in, a timeline/scoreboard
// reference model, directed cases and randomized traffic with backpressure.
module tb_alu_issue_ctrl;

   localparam int MUL_WAIT = 35;
   localparam int DW       = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [5:0]    cmd_funct;
   logic [DW-1:0] cmd_a, cmd_b;
   logic [5:0]    alu_signal;
   logic [DW-1:0] alu_dataA, alu_dataB;
   logic [DW-1:0] alu_out;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic          res_hi, res_err, busy;

   alu_issue_ctrl #(.MUL_WAIT(MUL_WAIT), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_funct  (cmd_funct),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_signal (alu_signal),
      .alu_dataA  (alu_dataA),
      .alu_dataB  (alu_dataB),
      .alu_out    (alu_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_hi     (res_hi),
      .res_err    (res_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit is_single(input logic [5:0] f);
      return (f == 6'd36) || (f == 6'd37) || (f == 6'd32) ||
             (f == 6'd34) || (f == 6'd42) || (f == 6'd2);
   endfunction

   function automatic logic [31:0] op_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         6'd36:   return a & b;
         6'd37:   return a | b;
         6'd32:   return a + b;
         6'd34:   return a - b;
         6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd2:    return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   // TotalALU stand-in: product lands in Hi/Lo only after 33 cycles of MULTU
   logic [31:0] alu_hi, alu_lo;
   int          mcnt;
   always @(posedge clk) begin
      if (reset) begin
         alu_hi <= '0; alu_lo <= '0; mcnt <= 0;
      end else if (alu_signal == 6'd25) begin
         mcnt <= mcnt + 1;
         if (mcnt == 32) {alu_hi, alu_lo} <= {32'd0, alu_dataA} * {32'd0, alu_dataB};
      end else begin
         mcnt <= 0;
      end
   end
   always_comb begin
      case (alu_signal)
         6'd16:   alu_out = alu_hi;
         6'd18:   alu_out = alu_lo;
         default: alu_out = op_ref(alu_signal, alu_dataA, alu_dataB);
      endcase
   end

   // reference model: expected result queue plus the cycle each entry becomes visible
   typedef struct {
      logic [31:0] d;
      logic        hi;
      logic        err;
   } res_t;

   res_t        q[$];
   int          acc_cyc[$];
   int          cyc = 0;
   int          due = 0;
   int          mul_sw = -1;
   bit          inflight = 0;
   bit          after_rst = 0;
   logic [5:0]  exp_sig = '0;
   logic [31:0] exp_a = '0, exp_b = '0;
   bit          rr_mode = 0;
   bit          rr_fixed = 1;

   always @(posedge clk) begin
      #1;
      res_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rr_fixed;
   end

   always @(negedge clk) begin
      bit          exp_v;
      logic [5:0]  nsig;
      logic [63:0] prod;
      res_t        r;
      cyc++;
      if (reset) begin
         q.delete();
         inflight  = 0;
         mul_sw    = -1;
         exp_sig   = '0;
         exp_a     = '0;
         exp_b     = '0;
         after_rst = 1;
      end else begin
         if (after_rst) begin
            chk("rst_res_data", res_data, 0);
            chk("rst_res_hi", res_hi, 0);
            chk("rst_res_err", res_err, 0);
            after_rst = 0;
         end
         chk("cmd_ready", cmd_ready, !inflight);
         chk("busy", busy, inflight);
         chk("alu_signal", alu_signal, exp_sig);
         chk("alu_dataA", alu_dataA, exp_a);
         chk("alu_dataB", alu_dataB, exp_b);
         exp_v = inflight && (q.size() > 0) && (cyc >= due);
         chk("res_valid", res_valid, exp_v);
         if (exp_v) begin
            chk("res_data", res_data, q[0].d);
            chk("res_hi", res_hi, q[0].hi);
            chk("res_err", res_err, q[0].err);
         end
         nsig = exp_sig;
         if (exp_v && res_ready) begin
            void'(q.pop_front());
            if (q.size() > 0) begin
               due  = cyc + 2;
               nsig = 6'd18;
            end else begin
               inflight = 0;
            end
         end else if (!inflight && cmd_valid) begin
            acc_cyc.push_back(cyc);
            inflight = 1;
            if (is_single(cmd_funct)) begin
               r.d = op_ref(cmd_funct, cmd_a, cmd_b); r.hi = 0; r.err = 0;
               q.push_back(r);
               due = cyc + 2;
               nsig = cmd_funct; exp_a = cmd_a; exp_b = cmd_b;
            end else if (cmd_funct == 6'd25) begin
               prod = {32'd0, cmd_a} * {32'd0, cmd_b};
               r.d = prod[63:32]; r.hi = 1; r.err = 0;
               q.push_back(r);
               r.d = prod[31:0]; r.hi = 0;
               q.push_back(r);
               due = cyc + MUL_WAIT + 2;
               mul_sw = cyc + MUL_WAIT + 1;
               nsig = 6'd25; exp_a = cmd_a; exp_b = cmd_b;
            end else begin
               r.d = '0; r.hi = 0; r.err = 1;
               q.push_back(r);
               due = cyc + 1;
            end
         end
         if (cyc + 1 == mul_sw) nsig = 6'd16;
         exp_sig = nsig;
      end
   end

   task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bit done = 0;
      cmd_funct = f; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready && !reset) done = 1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!done) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      bit idle = 0;
      for (int i = 0; i < 500 && !idle; i++) begin
         @(posedge clk); #2;
         if (cmd_ready) idle = 1;
      end
      if (!idle) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      int          sel;
      logic [5:0]  f;
      logic [5:0]  singles [6];
      singles = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2};
      reset = 1'b1; cmd_valid = 1'b0; cmd_funct = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      send(6'd32, 32'd5, 32'd7);
      drain();

      rr_fixed = 1'b0;
      send(6'd34, 32'd3, 32'd5);
      fork
         begin repeat (6) @(posedge clk); rr_fixed = 1'b1; end
      join_none
      send(6'd37, 32'h0F0F_0000, 32'h0000_00F0);
      drain();

      send(6'd25, 32'hFFFF_FFFF, 32'd2);
      drain();

      send(6'd7, 32'd1, 32'd1);
      drain();

      send(6'd25, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send(6'd32, 32'd1, 32'd1);
      drain();

      k = acc_cyc.size();
      send(6'd42, 32'hFFFF_FFFF, 32'd1);
      send(6'd42, 32'd1, 32'hFFFF_FFFF);
      drain();
      if (acc_cyc.size() == k + 2) chk("b2b_accept_gap", acc_cyc[k+1] - acc_cyc[k], 3);
      else chk("b2b_accept_count", acc_cyc.size() - k, 2);

      rr_mode = 1;
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 13);
         if (sel < 12) f = singles[sel % 6];
         else if (sel == 12) f = 6'd25;
         else begin
            f = 6'($urandom_range(0, 63));
            while (is_single(f) || f == 6'd25) f = 6'($urandom_range(0, 63));
         end
         send(f, $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
         #0;
      end
      drain();
      rr_mode = 0;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
